// File: rtl/lcg_stim_pkg.sv
// Shared LCG constants, step function and checker FSM states for the stimulus link.
package lcg_stim_pkg;

    localparam logic [31:0] LCG_MUL      = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC      = 32'h3039;
    localparam logic [31:0] DEFAULT_SEED = 32'd2048741382;

    typedef enum logic [1:0] {IDLE, GEN, WAIT, DONE} state_t;

    function automatic logic [31:0] lcg_next(input logic [31:0] s);
        return s * LCG_MUL + LCG_INC;
    endfunction

endpackage

// File: rtl/lcg_word_gen.sv
// Steps the LCG once per enabled cycle and assembles a WIDTH-bit word, low chunk first.
module lcg_word_gen
    import lcg_stim_pkg::*;
#(
    parameter int unsigned WIDTH = 143
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [31:0]      seed,
    input  logic             step,
    output logic             word_ready,
    output logic [WIDTH-1:0] word
);

    localparam int unsigned NCHUNK = (WIDTH + 31) / 32;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic [31:0]      state_q;
    logic [31:0]      state_nxt;
    logic [IDX_W-1:0] idx_q;

    assign state_nxt  = lcg_next(state_q);
    // High during the step that writes the final chunk, so the word is complete next cycle.
    assign word_ready = step && (idx_q == IDX_W'(NCHUNK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            idx_q   <= '0;
        end else if (load) begin
            state_q <= seed;
            idx_q   <= '0;
        end else if (step) begin
            state_q <= state_nxt;
            idx_q   <= word_ready ? '0 : idx_q + 1'b1;
        end
    end

    for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
        localparam int unsigned CW = (WIDTH - 32 * k > 32) ? 32 : WIDTH - 32 * k;
        logic [CW-1:0] part_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                part_q <= '0;
            end else if (step && idx_q == IDX_W'(k)) begin
                part_q <= state_nxt[CW-1:0];
            end
        end

        assign word[32*k +: CW] = part_q;
    end

endmodule

// File: rtl/lcg_stream_checker.sv
// Regenerates the seeded LCG word stream and scores received words against it.
module lcg_stream_checker
    import lcg_stim_pkg::*;
#(
    parameter int unsigned WIDTH = 143
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed_i,
    input  logic [31:0]      cycles_i,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [31:0]      first_err_idx,
    output logic [31:0]      word_count
);

    state_t state_q, state_d;

    logic             load;
    logic             step;
    logic             word_ready;
    logic             xfer;
    logic             mismatch;
    logic [WIDTH-1:0] exp_word;
    logic [32:0]      remaining_q;
    logic [15:0]      err_count_q;
    logic [15:0]      err_next;
    logic [31:0]      first_err_q;
    logic [31:0]      word_count_q;
    logic             pass_q;

    lcg_word_gen #(.WIDTH(WIDTH)) u_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .seed       (seed_i),
        .step       (step),
        .word_ready (word_ready),
        .word       (exp_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = GEN;
                end
            end
            GEN: begin
                step = 1'b1;
                if (word_ready) state_d = WAIT;
            end
            WAIT: begin
                if (in_valid) begin
                    xfer    = 1'b1;
                    state_d = (remaining_q == 33'd1) ? DONE : GEN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mismatch = (in_data != exp_word);
    assign err_next = (mismatch && err_count_q != '1) ? err_count_q + 16'd1 : err_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_q  <= '0;
            err_count_q  <= '0;
            first_err_q  <= '1;
            word_count_q <= '0;
            pass_q       <= 1'b0;
        end else if (load) begin
            // 33 bits so cycles_i = 0xFFFFFFFF still yields 2^32 words.
            remaining_q  <= {1'b0, cycles_i} + 33'd1;
            err_count_q  <= '0;
            first_err_q  <= '1;
            word_count_q <= '0;
            pass_q       <= 1'b0;
        end else if (xfer) begin
            err_count_q  <= err_next;
            if (mismatch && first_err_q == '1) first_err_q <= word_count_q;
            word_count_q <= word_count_q + 32'd1;
            remaining_q  <= remaining_q - 33'd1;
            if (remaining_q == 33'd1) pass_q <= (err_next == '0);
        end
    end

    assign in_ready      = (state_q == WAIT);
    assign busy          = (state_q == GEN) || (state_q == WAIT);
    assign done          = (state_q == DONE);
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_q;
    assign word_count    = word_count_q;

endmodule

// File: tb/tb_lcg_stream_checker.sv
// Scoreboard bench: a 64-bit and a 143-bit checker fed from an independent LCG model.
module tb_lcg_stream_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start64 = 1'b0;
    logic [31:0]  seed64  = '0;
    logic [31:0]  cyc64   = '0;
    logic         v64     = 1'b0;
    logic [63:0]  d64     = '0;
    logic         rdy64, busy64, done64, pass64;
    logic [15:0]  err64;
    logic [31:0]  fei64, wc64;

    logic         start143 = 1'b0;
    logic [31:0]  seed143  = '0;
    logic [31:0]  cyc143   = '0;
    logic         v143     = 1'b0;
    logic [142:0] d143     = '0;
    logic         rdy143, busy143, done143, pass143;
    logic [15:0]  err143;
    logic [31:0]  fei143, wc143;

    lcg_stream_checker #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .start(start64), .seed_i(seed64), .cycles_i(cyc64),
        .in_valid(v64), .in_data(d64), .in_ready(rdy64), .busy(busy64), .done(done64),
        .pass(pass64), .err_count(err64), .first_err_idx(fei64), .word_count(wc64)
    );

    lcg_stream_checker #(.WIDTH(143)) u_dut143 (
        .clk(clk), .rst(rst), .start(start143), .seed_i(seed143), .cycles_i(cyc143),
        .in_valid(v143), .in_data(d143), .in_ready(rdy143), .busy(busy143), .done(done143),
        .pass(pass143), .err_count(err143), .first_err_idx(fei143), .word_count(wc143)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] err;
        logic [31:0] first;
        logic [31:0] wc;
    } sb_t;
    sb_t sb[$];

    // in_ready spacing monitor for the 143-bit checker
    int cyc = 0, last_cyc = 0, gap_bad = 0, rdy_cnt = 0;
    bit have_last = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!busy143) begin
            have_last <= 1'b0;
        end else if (rdy143) begin
            if (have_last && (cyc - last_cyc) != 6) gap_bad <= gap_bad + 1;
            have_last <= 1'b1;
            last_cyc  <= cyc;
            rdy_cnt   <= rdy_cnt + 1;
        end
    end

    function automatic logic [31:0] m_lcg(input logic [31:0] s);
        return s * 32'd1103515245 + 32'd12345;
    endfunction

    task automatic m_word(inout logic [31:0] st, output logic [142:0] w);
        logic [159:0] acc;
        for (int k = 0; k < 5; k++) begin
            st = m_lcg(st);
            acc[k*32 +: 32] = st;
        end
        w = acc[142:0];
    endtask

    task automatic run64(input logic [31:0] seed, input logic [31:0] n, input logic [63:0] data);
        seed64 = seed; cyc64 = n; d64 = data; v64 = 1'b1; start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
    endtask

    task automatic check64(input string tag, input logic [15:0] e_err, input logic [31:0] e_first,
                           input logic [31:0] e_wc, input logic e_pass);
        int t = 0;
        while (!done64 && t < 100) begin @(negedge clk); t++; end
        check({tag, "_done"}, done64, 1);
        check({tag, "_busy"}, busy64, 0);
        check({tag, "_pass"}, pass64, e_pass);
        check({tag, "_err"}, err64, e_err);
        check({tag, "_first"}, fei64, e_first);
        check({tag, "_wc"}, wc64, e_wc);
    endtask

    task automatic run143(input string tag, input int flip, input bit rnd, input bit mid);
        logic [31:0]  st;
        logic [142:0] w;
        logic [15:0]  m_err;
        logic [31:0]  m_first;
        sb_t          e;
        int           r0, g0, t;
        bit           got;
        st = 32'd2048741382; m_err = '0; m_first = '1;
        r0 = rdy_cnt; g0 = gap_bad;
        seed143 = st; cyc143 = 32'd100; start143 = 1'b1;
        @(negedge clk);
        start143 = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            m_word(st, w);
            if (i == flip) begin
                w[142] = ~w[142];
                m_err++;
                if (m_first == '1) m_first = i;
            end
            e.err = m_err; e.first = m_first; e.wc = i + 1;
            sb.push_back(e);
            d143 = w;
            got = 1'b0; t = 0;
            while (!got && t < 200) begin
                v143 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                got = v143 && rdy143;
                @(negedge clk);
                t++;
            end
            if (!got) begin
                check({tag, "_handshake_timeout"}, 0, 1);
                break;
            end
            e = sb.pop_front();
            check({tag, "_sb_err"}, err143, e.err);
            check({tag, "_sb_first"}, fei143, e.first);
            check({tag, "_sb_wc"}, wc143, e.wc);
            if (mid && i == 49) begin
                start143 = 1'b1; seed143 = '0; cyc143 = '0;
                @(negedge clk);
                start143 = 1'b0;
            end
        end
        v143 = 1'b0;
        t = 0;
        while (!done143 && t < 50) begin @(negedge clk); t++; end
        check({tag, "_done"}, done143, 1);
        check({tag, "_pass"}, pass143, (flip < 0));
        check({tag, "_err"}, err143, (flip < 0) ? 0 : 1);
        check({tag, "_first"}, fei143, (flip < 0) ? 32'hFFFFFFFF : flip);
        check({tag, "_wc"}, wc143, 101);
        if (!rnd) begin
            #1;
            check({tag, "_ready_cnt"}, rdy_cnt - r0, 101);
            check({tag, "_ready_gap"}, gap_bad - g0, 0);
        end
        sb.delete();
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check("rst_ready", rdy143, 0);
        check("rst_busy", busy143, 0);
        check("rst_done", done143, 0);
        check("rst_pass", pass143, 0);
        check("rst_err", err143, 0);
        check("rst_first", fei143, 32'hFFFFFFFF);
        check("rst_wc", wc143, 0);
        rst = 1'b0;
        @(negedge clk);

        run64(32'd0, 32'd0, 64'hD3DC167E_00003039);
        check64("w64_ok", 16'd0, 32'hFFFFFFFF, 32'd1, 1'b1);
        run64(32'd0, 32'd0, 64'hD3DC167E_00003038);
        check64("w64_bad", 16'd1, 32'd0, 32'd1, 1'b0);
        v64 = 1'b0;

        run143("w143_ok", -1, 1'b0, 1'b0);
        run143("w143_flip37", 37, 1'b0, 1'b0);
        run143("w143_rnd", -1, 1'b1, 1'b1);

        // saturation on the 64-bit checker: every regenerated word is non-zero
        run64(32'd0, 32'd70000, 64'd0);
        t = 0;
        while (err64 != 16'hFFFF && t < 200000) begin @(negedge clk); t++; end
        check("sat_reach", err64, 16'hFFFF);
        repeat (30) @(negedge clk);
        check("sat_hold", err64, 16'hFFFF);
        check("sat_first", fei64, 0);
        check("sat_busy", busy64, 1);
        check("sat_words_advance", (wc64 > 32'd65535), 1);

        t = 0;
        while (rdy64 && t < 10) begin @(negedge clk); t++; end
        #2 rst = 1'b1;
        #1;
        check("arst_ready64", rdy64, 0);
        check("arst_busy64", busy64, 0);
        check("arst_done64", done64, 0);
        check("arst_err64", err64, 0);
        check("arst_first64", fei64, 32'hFFFFFFFF);
        check("arst_wc64", wc64, 0);
        check("arst_done143", done143, 0);
        check("arst_pass143", pass143, 0);
        check("arst_wc143", wc143, 0);
        @(negedge clk);
        rst = 1'b0; v64 = 1'b0;
        @(negedge clk);

        run64(32'd0, 32'd0, 64'hD3DC167E_00003039);
        check64("post_rst", 16'd0, 32'hFFFFFFFF, 32'd1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
